// File: rtl/sample_pkg.sv
// Shared types and constants for the sample sequencer: FSM state encoding,
// signed sample word and path-select mode codes.
package sample_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADC_START,
        ADC_WAIT,
        FILT,
        DAC_START,
        DAC_WAIT
    } seq_state_t;

    typedef logic signed [15:0] sample_t;

    localparam logic [1:0] MODE_MUTE   = 2'b00;
    localparam logic [1:0] MODE_BYPASS = 2'b01;
    localparam logic [1:0] MODE_FILT   = 2'b10;

    // Both 10 and 11 select the filter path.
    function automatic logic is_filt_mode(input logic [1:0] mode);
        return mode[1];
    endfunction

endpackage

// File: rtl/sample_sequencer_period_counter.sv
// Free-running sample-period counter: counts 0..DIVIDER-1 while enabled,
// holds while disabled, and flags the last count as a one-cycle tick.
module period_counter #(
    parameter int unsigned DIVIDER = 50
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic enable_i,
    output logic tick_o
);

    localparam logic [15:0] LAST = 16'(DIVIDER - 1);

    logic [15:0] r_count;

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_count <= '0;
        end else if (enable_i) begin
            r_count <= (r_count == LAST) ? '0 : r_count + 16'd1;
        end
    end

    // Gated by enable so a paused counter parked at LAST does not repeat the tick.
    assign tick_o = enable_i && (r_count == LAST);

endmodule

// File: rtl/sample_sequencer.sv
// Sample sequencer: per period tick, reads one ADC sample, optionally routes it
// through an external filter, and writes the result to the DAC.
// Optional build macro SEQ_OVERRUN_CNT_EN adds the saturating overrun_cnt_o.
module sample_sequencer
    import sample_pkg::*;
#(
    parameter int unsigned DIVIDER      = 50,
    parameter int unsigned FILT_TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        enable_i,
    input  logic [1:0]  mode_i,
    output logic        adc_start_o,
    input  logic        adc_idle_i,
    input  sample_t     adc_data_i,
    output logic        filt_valid_o,
    output sample_t     filt_data_o,
    input  logic        filt_valid_i,
    input  sample_t     filt_data_i,
    output logic        dac_start_o,
    output sample_t     dac_data_o,
    input  logic        dac_idle_i,
    output logic        busy_o,
    output logic        overrun_o,
    output logic        timeout_o
`ifdef SEQ_OVERRUN_CNT_EN
    ,
    output logic [7:0]  overrun_cnt_o
`endif
);

    localparam int unsigned CW = $clog2(FILT_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_TIMEOUT - 1);

    seq_state_t    r_state;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_mode;
    sample_t       r_sample;
    sample_t       r_dac_data;
    logic          r_timeout;
    logic          r_overrun;
    logic          w_tick;
    logic          w_ovr_evt;

    period_counter #(
        .DIVIDER(DIVIDER)
    ) u_period_counter (
        .clk_i   (clk_i),
        .reset_ni(reset_ni),
        .enable_i(enable_i),
        .tick_o  (w_tick)
    );

    // A tick seen while DAC_WAIT is returning to IDLE still counts as an overrun.
    assign w_ovr_evt = w_tick && (r_state != IDLE);

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_mode     <= MODE_MUTE;
            r_sample   <= '0;
            r_dac_data <= '0;
            r_timeout  <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            r_overrun <= w_ovr_evt;
            case (r_state)
                IDLE: begin
                    if (w_tick) r_state <= ADC_START;
                end
                ADC_START: begin
                    r_mode  <= mode_i;
                    r_cnt   <= '0;
                    r_state <= ADC_WAIT;
                end
                ADC_WAIT: begin
                    if (r_cnt == '0) begin
                        r_cnt <= CW'(1);
                    end else if (adc_idle_i) begin
                        r_sample <= adc_data_i;
                        r_cnt    <= '0;
                        if (is_filt_mode(r_mode)) begin
                            r_state <= FILT;
                        end else begin
                            r_dac_data <= (r_mode == MODE_BYPASS) ? adc_data_i : '0;
                            r_state    <= DAC_START;
                        end
                    end
                end
                FILT: begin
                    if (filt_valid_i) begin
                        r_dac_data <= filt_data_i;
                        r_state    <= DAC_START;
                    end else if (r_cnt == CNT_LAST) begin
                        // Timeout keeps the previous DAC word by leaving r_dac_data alone.
                        r_timeout <= 1'b1;
                        r_state   <= DAC_START;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DAC_START: begin
                    r_cnt   <= '0;
                    r_state <= DAC_WAIT;
                end
                DAC_WAIT: begin
                    if (r_cnt == '0) begin
                        r_cnt <= CW'(1);
                    end else if (dac_idle_i) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign adc_start_o  = (r_state == ADC_START);
    assign filt_valid_o = (r_state == FILT) && (r_cnt == '0);
    assign filt_data_o  = r_sample;
    assign dac_start_o  = (r_state == DAC_START);
    assign dac_data_o   = r_dac_data;
    assign busy_o       = (r_state != IDLE);
    assign overrun_o    = r_overrun;
    assign timeout_o    = r_timeout;

`ifdef SEQ_OVERRUN_CNT_EN
    logic [7:0] r_ovr_cnt;

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_ovr_cnt <= '0;
        end else if (w_ovr_evt && (r_ovr_cnt != '1)) begin
            r_ovr_cnt <= r_ovr_cnt + 8'd1;
        end
    end

    assign overrun_cnt_o = r_ovr_cnt;
`endif

endmodule

// File: tb/tb_sample_sequencer.sv
// Directed bench for sample_sequencer: main instance with DIVIDER=50 and a
// second instance with DIVIDER=8 for overrun scenarios.
module tb_sample_sequencer;

    logic        clk_i = 1'b0;
    logic        reset_ni = 1'b0;
    logic        enable_i = 1'b1;
    logic [1:0]  mode_i = 2'b01;
    logic        adc_idle_i = 1'b1;
    logic [15:0] adc_data_i = 16'h0000;
    logic        filt_valid_i = 1'b0;
    logic [15:0] filt_data_i = 16'h0000;
    logic        dac_idle_i = 1'b1;
    logic        adc_start_o, filt_valid_o, dac_start_o, busy_o, overrun_o, timeout_o;
    logic [15:0] filt_data_o, dac_data_o;

    logic        en8 = 1'b0;
    logic        adc_idle8 = 1'b1;
    logic        dac_idle8 = 1'b1;
    logic        o8_adc_start, o8_fv, o8_dac_start, o8_busy, o8_overrun, o8_timeout;
    logic [15:0] o8_fdata, o8_dac_data;
`ifdef SEQ_OVERRUN_CNT_EN
    logic [7:0]  m_ocnt, o8_ocnt;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    int          s_started, s_done, s_start_cyc, s_adc_starts, s_fv, s_fv_cyc, s_to, s_to_cyc;
    int          s_dac_starts, s_dac_cyc, s_ovr;
    logic [15:0] s_fdata, s_dac_data, s_dac_end;

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    sample_sequencer #(.DIVIDER(50), .FILT_TIMEOUT(16)) u_dut (
        .clk_i(clk_i), .reset_ni(reset_ni), .enable_i(enable_i), .mode_i(mode_i),
        .adc_start_o(adc_start_o), .adc_idle_i(adc_idle_i), .adc_data_i(adc_data_i),
        .filt_valid_o(filt_valid_o), .filt_data_o(filt_data_o),
        .filt_valid_i(filt_valid_i), .filt_data_i(filt_data_i),
        .dac_start_o(dac_start_o), .dac_data_o(dac_data_o), .dac_idle_i(dac_idle_i),
        .busy_o(busy_o), .overrun_o(overrun_o), .timeout_o(timeout_o)
`ifdef SEQ_OVERRUN_CNT_EN
        , .overrun_cnt_o(m_ocnt)
`endif
    );

    sample_sequencer #(.DIVIDER(8), .FILT_TIMEOUT(16)) u_ovr (
        .clk_i(clk_i), .reset_ni(reset_ni), .enable_i(en8), .mode_i(mode_i),
        .adc_start_o(o8_adc_start), .adc_idle_i(adc_idle8), .adc_data_i(adc_data_i),
        .filt_valid_o(o8_fv), .filt_data_o(o8_fdata),
        .filt_valid_i(filt_valid_i), .filt_data_i(filt_data_i),
        .dac_start_o(o8_dac_start), .dac_data_o(o8_dac_data), .dac_idle_i(dac_idle8),
        .busy_o(o8_busy), .overrun_o(o8_overrun), .timeout_o(o8_timeout)
`ifdef SEQ_OVERRUN_CNT_EN
        , .overrun_cnt_o(o8_ocnt)
`endif
    );

    // Runs one sample on the main instance, acting as ADC, filter and DAC
    // responders; flat=0 means the filter never answers.
    task automatic do_sample(input logic [1:0] md, input logic [15:0] aval, input int alat,
                             input int flat, input logic [15:0] fval, input int dlat,
                             input bit drop_en);
        int n;
        int a_cnt, f_cnt, d_cnt;
        bit dac_seen;
        mode_i = md;
        s_started = 0; s_done = 0; s_adc_starts = 0; s_fv = 0; s_fv_cyc = 0; s_to = 0;
        s_to_cyc = 0; s_dac_starts = 0; s_dac_cyc = 0; s_ovr = 0;
        s_fdata = 16'hxxxx; s_dac_data = 16'hxxxx;
        n = 0;
        while (!adc_start_o && n < 200) begin
            @(posedge clk_i); #1; n++;
        end
        s_started = adc_start_o ? 1 : 0;
        s_start_cyc = cyc;
        a_cnt = 0; f_cnt = 0; d_cnt = 0; dac_seen = 0;
        for (int k = 0; k < 300 && s_done == 0; k++) begin
            if (filt_valid_i) begin
                filt_valid_i = 1'b0; filt_data_i = 16'hBEEF;
            end
            if (overrun_o) s_ovr++;
            if (timeout_o) begin s_to++; s_to_cyc = cyc; end
            if (adc_start_o) begin
                s_adc_starts++; adc_idle_i = 1'b0; adc_data_i = 16'hDEAD; a_cnt = alat;
                if (drop_en) enable_i = 1'b0;
            end else if (a_cnt > 0) begin
                a_cnt--;
                if (a_cnt == 0) begin adc_idle_i = 1'b1; adc_data_i = aval; end
            end
            if (filt_valid_o) begin
                s_fv++; s_fv_cyc = cyc; s_fdata = filt_data_o; f_cnt = flat;
            end else if (f_cnt > 0) begin
                f_cnt--;
                if (f_cnt == 0) begin filt_valid_i = 1'b1; filt_data_i = fval; end
            end
            if (dac_start_o) begin
                s_dac_starts++; s_dac_cyc = cyc; s_dac_data = dac_data_o;
                dac_seen = 1; dac_idle_i = 1'b0; d_cnt = dlat;
            end else if (d_cnt > 0) begin
                d_cnt--;
                if (d_cnt == 0) dac_idle_i = 1'b1;
            end
            if (dac_seen && !busy_o) s_done = 1;
            else begin @(posedge clk_i); #1; end
        end
        s_dac_end = dac_data_o;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk_i);
        #1;
        n_cmp++; if (adc_start_o !== 1'b0) begin n_err++; $display("FAIL rst_adc_start: got %b want 0", adc_start_o); end
        n_cmp++; if (dac_start_o !== 1'b0) begin n_err++; $display("FAIL rst_dac_start: got %b want 0", dac_start_o); end
        n_cmp++; if (filt_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_filt_valid: got %b want 0", filt_valid_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy_o); end
        n_cmp++; if (overrun_o !== 1'b0) begin n_err++; $display("FAIL rst_overrun: got %b want 0", overrun_o); end
        n_cmp++; if (timeout_o !== 1'b0) begin n_err++; $display("FAIL rst_timeout: got %b want 0", timeout_o); end
        n_cmp++; if (dac_data_o !== 16'h0000) begin n_err++; $display("FAIL rst_dac_data: got %h want 0000", dac_data_o); end
        n_cmp++; if (filt_data_o !== 16'h0000) begin n_err++; $display("FAIL rst_filt_data: got %h want 0000", filt_data_o); end
`ifdef SEQ_OVERRUN_CNT_EN
        n_cmp++; if (m_ocnt !== 8'd0) begin n_err++; $display("FAIL rst_ovr_cnt: got %0d want 0", m_ocnt); end
`endif
    endtask

    task automatic test_bypass();
        int rel;
        reset_ni = 1'b1;
        rel = cyc;
        do_sample(2'b01, 16'h1234, 20, 0, 16'h0000, 20, 0);
        n_cmp++; if (s_started != 1 || s_start_cyc - rel != 50) begin n_err++; $display("FAIL byp_first_start: got %0d cycles want 50", s_start_cyc - rel); end
        n_cmp++; if (s_done != 1) begin n_err++; $display("FAIL byp_done: got %0d want 1", s_done); end
        n_cmp++; if (s_dac_data !== 16'h1234) begin n_err++; $display("FAIL byp_dac_data: got %h want 1234", s_dac_data); end
        n_cmp++; if (s_dac_starts != 1) begin n_err++; $display("FAIL byp_dac_pulses: got %0d want 1", s_dac_starts); end
        n_cmp++; if (s_dac_cyc - s_start_cyc != 21) begin n_err++; $display("FAIL byp_dac_latency: got %0d want 21", s_dac_cyc - s_start_cyc); end
        n_cmp++; if (s_fv != 0) begin n_err++; $display("FAIL byp_filt_valid: got %0d want 0", s_fv); end
        n_cmp++; if (s_adc_starts != 1) begin n_err++; $display("FAIL byp_adc_pulses: got %0d want 1", s_adc_starts); end
        n_cmp++; if (s_ovr != 0) begin n_err++; $display("FAIL byp_overrun: got %0d want 0", s_ovr); end
        n_cmp++; if (s_dac_end !== 16'h1234) begin n_err++; $display("FAIL byp_dac_hold: got %h want 1234", s_dac_end); end
    endtask

    task automatic test_mute();
        do_sample(2'b00, 16'h7FFF, 3, 0, 16'h0000, 3, 0);
        n_cmp++; if (s_dac_data !== 16'h0000) begin n_err++; $display("FAIL mute_dac_data: got %h want 0000", s_dac_data); end
        n_cmp++; if (s_fv != 0) begin n_err++; $display("FAIL mute_filt_valid: got %0d want 0", s_fv); end
        n_cmp++; if (s_dac_starts != 1 || s_done != 1) begin n_err++; $display("FAIL mute_dac_pulses: got %0d want 1", s_dac_starts); end
    endtask

    task automatic test_filter();
        do_sample(2'b10, 16'h0100, 3, 3, 16'hFF00, 3, 0);
        n_cmp++; if (s_fv != 1) begin n_err++; $display("FAIL filt_valid_pulses: got %0d want 1", s_fv); end
        n_cmp++; if (s_fdata !== 16'h0100) begin n_err++; $display("FAIL filt_data_out: got %h want 0100", s_fdata); end
        n_cmp++; if (s_dac_data !== 16'hFF00) begin n_err++; $display("FAIL filt_dac_data: got %h want ff00", s_dac_data); end
        n_cmp++; if (s_to != 0) begin n_err++; $display("FAIL filt_timeout: got %0d want 0", s_to); end
        n_cmp++; if (s_dac_cyc - s_fv_cyc != 4) begin n_err++; $display("FAIL filt_capture_latency: got %0d want 4", s_dac_cyc - s_fv_cyc); end
    endtask

    task automatic test_timeout();
        do_sample(2'b01, 16'h0042, 3, 0, 16'h0000, 3, 0);
        n_cmp++; if (s_dac_data !== 16'h0042) begin n_err++; $display("FAIL to_prev_word: got %h want 0042", s_dac_data); end
        do_sample(2'b11, 16'h5555, 3, 0, 16'h0000, 3, 0);
        n_cmp++; if (s_to != 1) begin n_err++; $display("FAIL to_pulses: got %0d want 1", s_to); end
        n_cmp++; if (s_to_cyc - s_fv_cyc != 16) begin n_err++; $display("FAIL to_delay: got %0d want 16", s_to_cyc - s_fv_cyc); end
        n_cmp++; if (s_dac_data !== 16'h0042) begin n_err++; $display("FAIL to_dac_data: got %h want 0042", s_dac_data); end
        n_cmp++; if (s_dac_starts != 1 || s_done != 1) begin n_err++; $display("FAIL to_dac_pulses: got %0d want 1", s_dac_starts); end
    endtask

    task automatic test_enable_hold();
        int starts, x, n;
        do_sample(2'b01, 16'h0321, 3, 0, 16'h0000, 3, 1);
        n_cmp++; if (s_done != 1 || s_dac_data !== 16'h0321) begin n_err++; $display("FAIL en_sample_completes: got %h want 0321", s_dac_data); end
        starts = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk_i); #1;
            if (adc_start_o) starts++;
        end
        n_cmp++; if (starts != 0) begin n_err++; $display("FAIL en_no_start_disabled: got %0d want 0", starts); end
        enable_i = 1'b1;
        x = cyc; n = 0;
        while (!adc_start_o && n < 200) begin @(posedge clk_i); #1; n++; end
        n_cmp++; if (cyc - x != 50) begin n_err++; $display("FAIL en_resume_latency: got %0d want 50", cyc - x); end
        do_sample(2'b01, 16'h0777, 3, 0, 16'h0000, 3, 0);
        n_cmp++; if (s_dac_data !== 16'h0777) begin n_err++; $display("FAIL en_resume_dac: got %h want 0777", s_dac_data); end
    endtask

    task automatic test_mid_reset();
        int n, rel, first, dstarts;
        n = 0;
        while (!adc_start_o && n < 200) begin @(posedge clk_i); #1; n++; end
        adc_idle_i = 1'b0; adc_data_i = 16'hDEAD;
        repeat (3) begin @(posedge clk_i); #1; end
        reset_ni = 1'b0;
        @(posedge clk_i); #1;
        n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL mr_busy: got %b want 0", busy_o); end
        n_cmp++; if (adc_start_o !== 1'b0 || dac_start_o !== 1'b0 || filt_valid_o !== 1'b0) begin
            n_err++; $display("FAIL mr_strobes: got %b%b%b want 000", adc_start_o, dac_start_o, filt_valid_o); end
        n_cmp++; if (overrun_o !== 1'b0 || timeout_o !== 1'b0) begin n_err++; $display("FAIL mr_status: got %b%b want 00", overrun_o, timeout_o); end
        n_cmp++; if (dac_data_o !== 16'h0000) begin n_err++; $display("FAIL mr_dac_data: got %h want 0000", dac_data_o); end
        n_cmp++; if (filt_data_o !== 16'h0000) begin n_err++; $display("FAIL mr_filt_data: got %h want 0000", filt_data_o); end
        reset_ni = 1'b1; adc_idle_i = 1'b1;
        rel = cyc; first = -1; dstarts = 0;
        for (int k = 0; k < 60 && first < 0; k++) begin
            @(posedge clk_i); #1;
            if (dac_start_o) dstarts++;
            if (adc_start_o) first = cyc - rel;
        end
        n_cmp++; if (dstarts != 0) begin n_err++; $display("FAIL mr_no_dac_start: got %0d want 0", dstarts); end
        n_cmp++; if (first != 50) begin n_err++; $display("FAIL mr_next_start: got %0d want 50", first); end
        enable_i = 1'b0;
    endtask

    task automatic test_overrun();
        int p, first, second, ovr, busy_left;
        mode_i = 2'b01; adc_idle8 = 1'b1; dac_idle8 = 1'b1;
        en8 = 1'b1;
        p = cyc; first = -1; second = -1; ovr = 0; busy_left = 0;
        for (int k = 1; k <= 48; k++) begin
            @(posedge clk_i); #1;
            if (o8_overrun) ovr++;
            if (o8_adc_start) begin
                if (first < 0) begin first = cyc - p; adc_idle8 = 1'b0; busy_left = 30; end
                else if (second < 0) second = cyc - p;
            end else if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) adc_idle8 = 1'b1;
            end
        end
        n_cmp++; if (first != 8) begin n_err++; $display("FAIL ovr_first_start: got %0d want 8", first); end
        n_cmp++; if (ovr != 4) begin n_err++; $display("FAIL ovr_pulses: got %0d want 4", ovr); end
        n_cmp++; if (second != 48) begin n_err++; $display("FAIL ovr_second_start: got %0d want 48", second); end
`ifdef SEQ_OVERRUN_CNT_EN
        n_cmp++; if (o8_ocnt !== 8'd4) begin n_err++; $display("FAIL ovr_cnt_match: got %0d want 4", o8_ocnt); end
        adc_idle8 = 1'b0;
        for (int k = 0; k < 2200; k++) begin
            @(posedge clk_i); #1;
            if (o8_overrun) ovr++;
        end
        adc_idle8 = 1'b1;
        n_cmp++; if (ovr < 256) begin n_err++; $display("FAIL ovr_enough_pulses: got %0d want >=256", ovr); end
        n_cmp++; if (o8_ocnt !== 8'd255) begin n_err++; $display("FAIL ovr_cnt_saturate: got %0d want 255", o8_ocnt); end
`endif
        en8 = 1'b0;
        repeat (20) @(posedge clk_i);
        #1;
        n_cmp++; if (o8_busy !== 1'b0) begin n_err++; $display("FAIL ovr_settles_idle: got %b want 0", o8_busy); end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_mute();
        test_filter();
        test_timeout();
        test_enable_hold();
        test_mid_reset();
        test_overrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "watchdog");
    end

endmodule
